pcpi_vec: RTL and testbench

PCPI_VEC -- requirements
Module: pcpi_vec

---
 rtl/pcpi_vec.sv | 230 +++++++++++++++++++++++
 tb/tb_pcpi_vec.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_vec.sv
// PCPI vector coprocessor: vsetvli, strided vlse.v/vsse.v and an element-wise
// multiply-accumulate (vdot.vv) over 32 registers of VLEN bits with SEW fixed at 32.
module pcpi_vec #(
  parameter int VLEN = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_cpurs1,
  input  logic [31:0] pcpi_cpurs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int VLMAX = VLEN / 32;
  localparam int EW    = $clog2(VLMAX);
  localparam int IW    = EW + 1;
  localparam logic [31:0] VLMAX_W = 32'(VLMAX);

  typedef enum logic [2:0] {IDLE, EXEC, MEM_REQ, MEM_WAIT, DONE} state_t;
  typedef enum logic [1:0] {OP_VSETVLI, OP_VLSE, OP_VSSE, OP_VDOT} op_t;

  state_t          state_r;
  op_t             op_r;
  logic [4:0]      vd_r, vs1_r, vs2_r;
  logic [10:0]     vtype_fld_r;
  logic [10:0]     vtype_r;
  logic [31:0]     rs1_r, rs2_r, vl_r;
  logic [IW-1:0]   idx_r;
  logic [VLEN-1:0] vreg_r [32];

  logic            dec_valid_s;
  op_t             dec_op_s;
  logic [EW-1:0]   eidx_s;
  logic            more_s;
  logic [31:0]     new_vl_s;
  logic [31:0]     vd_e_s, vs1_e_s, vs2_e_s;
  logic            rf_we_s;
  logic [31:0]     rf_wdata_s;

  function automatic logic [31:0] elem_get(input logic [VLEN-1:0] v, input logic [EW-1:0] i);
    return v[{i, 5'b00000} +: 32];
  endfunction

  assign eidx_s   = idx_r[EW-1:0];
  assign more_s   = ({{(32-IW){1'b0}}, idx_r} < vl_r);
  assign new_vl_s = (rs1_r > VLMAX_W) ? VLMAX_W : rs1_r;
  assign vd_e_s   = elem_get(vreg_r[vd_r], eidx_s);
  assign vs1_e_s  = elem_get(vreg_r[vs1_r], eidx_s);
  assign vs2_e_s  = elem_get(vreg_r[vs2_r], eidx_s);

  // Instruction decode of the offered word; anything unmatched is left to the CPU.
  always_comb begin
    dec_valid_s = 1'b0;
    dec_op_s    = OP_VSETVLI;
    if (pcpi_insn[6:0] == 7'b1010111 && pcpi_insn[14:12] == 3'b111 && !pcpi_insn[31]) begin
      dec_valid_s = 1'b1;
      dec_op_s    = OP_VSETVLI;
    end else if (pcpi_insn[6:0] == 7'b0000111 && pcpi_insn[14:12] == 3'b111 &&
                 pcpi_insn[28:26] == 3'b010) begin
      dec_valid_s = 1'b1;
      dec_op_s    = OP_VLSE;
    end else if (pcpi_insn[6:0] == 7'b0100111 && pcpi_insn[14:12] == 3'b111 &&
                 pcpi_insn[28:26] == 3'b010) begin
      dec_valid_s = 1'b1;
      dec_op_s    = OP_VSSE;
    end else if (pcpi_insn[6:0] == 7'b1010111 && pcpi_insn[14:12] == 3'b000 &&
                 pcpi_insn[31:26] == 6'b111001) begin
      dec_valid_s = 1'b1;
      dec_op_s    = OP_VDOT;
    end else begin
      dec_valid_s = 1'b0;
      dec_op_s    = OP_VSETVLI;
    end
  end

  // Register-file write port: one vdot element per EXEC cycle or one load element per ack.
  always_comb begin
    rf_we_s    = 1'b0;
    rf_wdata_s = 32'h0000_0000;
    case (state_r)
      EXEC: begin
        if (op_r == OP_VDOT && more_s) begin
          rf_we_s    = 1'b1;
          rf_wdata_s = vd_e_s + vs2_e_s * vs1_e_s;
        end else begin
          rf_we_s    = 1'b0;
        end
      end
      MEM_REQ: begin
        if (op_r == OP_VLSE && mem_ready) begin
          rf_we_s    = 1'b1;
          rf_wdata_s = mem_rdata;
        end else begin
          rf_we_s    = 1'b0;
        end
      end
      default: rf_we_s = 1'b0;
    endcase
  end

  // Vector register storage; deliberately not reset so partial results survive a reset.
  always_ff @(posedge clk) begin
    if (rf_we_s) begin
      vreg_r[vd_r][{eidx_s, 5'b00000} +: 32] <= rf_wdata_s;
    end
  end

  // Control FSM with all PCPI and memory outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      op_r        <= OP_VSETVLI;
      vd_r        <= 5'd0;
      vs1_r       <= 5'd0;
      vs2_r       <= 5'd0;
      vtype_fld_r <= 11'd0;
      vtype_r     <= 11'd0;
      rs1_r       <= 32'd0;
      rs2_r       <= 32'd0;
      vl_r        <= 32'd0;
      idx_r       <= '0;
      pcpi_wr     <= 1'b0;
      pcpi_rd     <= 32'd0;
      pcpi_wait   <= 1'b0;
      pcpi_ready  <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_wstrb   <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (pcpi_valid && dec_valid_s) begin
            op_r        <= dec_op_s;
            vd_r        <= pcpi_insn[11:7];
            vs1_r       <= pcpi_insn[19:15];
            vs2_r       <= pcpi_insn[24:20];
            vtype_fld_r <= pcpi_insn[30:20];
            rs1_r       <= pcpi_cpurs1;
            rs2_r       <= pcpi_cpurs2;
            idx_r       <= '0;
            pcpi_wait   <= 1'b1;
            state_r     <= EXEC;
          end
        end
        EXEC: begin
          case (op_r)
            OP_VSETVLI: begin
              vtype_r    <= vtype_fld_r;
              vl_r       <= new_vl_s;
              pcpi_rd    <= new_vl_s;
              pcpi_wr    <= 1'b1;
              pcpi_ready <= 1'b1;
              pcpi_wait  <= 1'b0;
              state_r    <= DONE;
            end
            OP_VDOT: begin
              if (more_s) begin
                idx_r      <= idx_r + IW'(1);
              end else begin
                pcpi_ready <= 1'b1;
                pcpi_wait  <= 1'b0;
                state_r    <= DONE;
              end
            end
            default: begin
              if (more_s) begin
                mem_valid <= 1'b1;
                mem_addr  <= rs1_r;
                mem_wstrb <= (op_r == OP_VSSE) ? 4'b1111 : 4'b0000;
                mem_wdata <= (op_r == OP_VSSE) ? vd_e_s : 32'd0;
                state_r   <= MEM_REQ;
              end else begin
                pcpi_ready <= 1'b1;
                pcpi_wait  <= 1'b0;
                state_r    <= DONE;
              end
            end
          endcase
        end
        MEM_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            idx_r     <= idx_r + IW'(1);
            state_r   <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // Address advances by the stride; wrap-around gives signed strides for free.
          if (more_s) begin
            mem_valid <= 1'b1;
            mem_addr  <= mem_addr + rs2_r;
            mem_wstrb <= (op_r == OP_VSSE) ? 4'b1111 : 4'b0000;
            mem_wdata <= (op_r == OP_VSSE) ? vd_e_s : 32'd0;
            state_r   <= MEM_REQ;
          end else begin
            pcpi_ready <= 1'b1;
            pcpi_wait  <= 1'b0;
            state_r    <= DONE;
          end
        end
        DONE: begin
          pcpi_ready <= 1'b0;
          pcpi_wr    <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          pcpi_ready <= 1'b0;
          pcpi_wr    <= 1'b0;
          pcpi_wait  <= 1'b0;
          mem_valid  <= 1'b0;
          mem_wstrb  <= 4'b0000;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_vec.sv
// Scoreboard bench for pcpi_vec: stimulus queues expected PCPI responses and memory
// requests; a monitor pops and compares them as the DUT presents them.
module tb_pcpi_vec;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_cpurs1, pcpi_cpurs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  pcpi_vec #(.VLEN(256)) dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_cpurs1(pcpi_cpurs1), .pcpi_cpurs2(pcpi_cpurs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  typedef struct { logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } mem_exp_t;
  typedef struct { logic wr; logic [31:0] rd; } rsp_exp_t;

  mem_exp_t    mem_q[$];
  rsp_exp_t    rsp_q[$];
  logic [31:0] mem_words [logic [31:0]];
  int          n_vec = 0;
  int          n_err = 0;
  int          wait_cnt = 0;
  int          ack_cnt = 0;
  bit          req_open = 1'b0;
  bit          ack_pending = 1'b0;

  localparam logic [31:0] VSETVLI = 32'h0081_7257;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] enc_vlse(input logic [4:0] vd);
    return {3'b000, 3'b010, 1'b1, 5'd2, 5'd1, 3'b111, vd, 7'b0000111};
  endfunction

  function automatic logic [31:0] enc_vsse(input logic [4:0] vs3);
    return {3'b000, 3'b010, 1'b1, 5'd2, 5'd1, 3'b111, vs3, 7'b0100111};
  endfunction

  function automatic logic [31:0] enc_vdot(input logic [4:0] vd, input logic [4:0] vs2,
                                           input logic [4:0] vs1);
    return {6'b111001, 1'b1, vs2, vs1, 3'b000, vd, 7'b1010111};
  endfunction

  task automatic expect_mem(input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata);
    mem_exp_t e;
    e.addr = addr; e.wstrb = wstrb; e.wdata = wdata;
    mem_q.push_back(e);
  endtask

  task automatic expect_rsp(input logic wr, input logic [31:0] rd);
    rsp_exp_t r;
    r.wr = wr; r.rd = rd;
    rsp_q.push_back(r);
  endtask

  task automatic run_insn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    bit got, saw_wait;
    @(negedge clk);
    pcpi_insn = insn; pcpi_cpurs1 = rs1; pcpi_cpurs2 = rs2; pcpi_valid = 1'b1;
    got = 1'b0; saw_wait = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (pcpi_wait) saw_wait = 1'b1;
      if (pcpi_ready) begin
        got = 1'b1;
        break;
      end
    end
    pcpi_valid = 1'b0;
    check("ready_seen", 32'(got), 32'd1);
    check("wait_seen", 32'(saw_wait), 32'd1);
    if (got) check("wait_low_at_ready", 32'(pcpi_wait), 32'd0);
  endtask

  // Memory responder: variable ack latency, read data returned with mem_ready.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_valid) begin
        if (wait_cnt >= ack_cnt % 3) begin
          mem_ready = 1'b1;
          mem_rdata = mem_words.exists(mem_addr) ? mem_words[mem_addr] : 32'd0;
          wait_cnt  = 0;
          ack_cnt++;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor: compares each completion pulse and each new memory request against the queues.
  initial begin
    rsp_exp_t r;
    mem_exp_t m;
    forever begin
      @(negedge clk); #1;
      if (!resetn) begin
        req_open = 1'b0;
        ack_pending = 1'b0;
      end else begin
        if (pcpi_ready) begin
          if (rsp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_ready: got pcpi_ready=1 expected no completion at %0t", $time);
          end else begin
            r = rsp_q.pop_front();
            check("pcpi_wr", 32'(pcpi_wr), 32'(r.wr));
            if (r.wr) check("pcpi_rd", pcpi_rd, r.rd);
          end
        end
        if (ack_pending) begin
          check("mem_gap", 32'(mem_valid), 32'd0);
          ack_pending = 1'b0;
          req_open = 1'b0;
        end else if (mem_valid && !req_open) begin
          req_open = 1'b1;
          if (mem_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_mem: got request addr 0x%08h expected none at %0t", mem_addr, $time);
          end else begin
            m = mem_q.pop_front();
            check("mem_addr", mem_addr, m.addr);
            check("mem_wstrb", 32'(mem_wstrb), 32'(m.wstrb));
            if (m.wstrb == 4'b1111) check("mem_wdata", mem_wdata, m.wdata);
          end
        end
        if (req_open && mem_ready) ack_pending = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt;
    bit prev, saw;
    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = 32'd0; pcpi_cpurs1 = 32'd0; pcpi_cpurs2 = 32'd0;
    for (int i = 0; i < 8; i++) begin
      mem_words[32'(400 + 4*i)]  = 32'(i + 1);
      mem_words[32'(600 + 4*i)]  = 32'(10 * (i + 1));
      mem_words[32'(1200 + 4*i)] = 32'hA500_0000 + 32'(i);
    end
    repeat (3) @(negedge clk);
    check("rst_ctrl", {24'd0, pcpi_wr, pcpi_wait, pcpi_ready, mem_valid, mem_wstrb}, 32'd0);
    check("rst_pcpi_rd", pcpi_rd, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    resetn = 1'b1;

    expect_rsp(1'b1, 32'd8); run_insn(VSETVLI, 32'd8, 32'd0);
    expect_rsp(1'b1, 32'd8); run_insn(VSETVLI, 32'd20, 32'd0);

    for (int i = 0; i < 8; i++) expect_mem(32'(400 + 4*i), 4'b0000, 32'd0);
    expect_rsp(1'b0, 32'd0); run_insn(enc_vlse(5'd1), 32'd400, 32'd4);
    for (int i = 0; i < 8; i++) expect_mem(32'(600 + 4*i), 4'b0000, 32'd0);
    expect_rsp(1'b0, 32'd0); run_insn(enc_vlse(5'd2), 32'd600, 32'd4);
    for (int i = 0; i < 8; i++) expect_mem(32'(1000 + 4*i), 4'b0000, 32'd0);
    expect_rsp(1'b0, 32'd0); run_insn(enc_vlse(5'd8), 32'd1000, 32'd4);

    expect_rsp(1'b0, 32'd0); run_insn(enc_vdot(5'd8, 5'd2, 5'd1), 32'd0, 32'd0);
    for (int i = 0; i < 8; i++) expect_mem(32'(800 + 4*i), 4'b1111, 32'(10 * (i + 1) * (i + 1)));
    expect_rsp(1'b0, 32'd0); run_insn(enc_vsse(5'd8), 32'd800, 32'd4);
    for (int i = 0; i < 8; i++) expect_mem(32'(828 - 4*i), 4'b1111, 32'(10 * (i + 1) * (i + 1)));
    expect_rsp(1'b0, 32'd0); run_insn(enc_vsse(5'd8), 32'd828, 32'hFFFF_FFFC);

    // Destination aliasing both sources: v1[i] = (i+1) + (i+1)^2.
    expect_rsp(1'b0, 32'd0); run_insn(enc_vdot(5'd1, 5'd1, 5'd1), 32'd0, 32'd0);
    for (int i = 0; i < 8; i++) expect_mem(32'(2000 + 4*i), 4'b1111, 32'((i + 1) + (i + 1) * (i + 1)));
    expect_rsp(1'b0, 32'd0); run_insn(enc_vsse(5'd1), 32'd2000, 32'd4);

    expect_rsp(1'b1, 32'd3); run_insn(VSETVLI, 32'd3, 32'd0);
    for (int i = 0; i < 3; i++) expect_mem(32'(900 + 8*i), 4'b1111, 32'(10 * (i + 1) * (i + 1)));
    expect_rsp(1'b0, 32'd0); run_insn(enc_vsse(5'd8), 32'd900, 32'd8);

    expect_rsp(1'b1, 32'd0); run_insn(VSETVLI, 32'd0, 32'd0);
    expect_rsp(1'b0, 32'd0); run_insn(enc_vlse(5'd1), 32'd400, 32'd4);
    expect_rsp(1'b0, 32'd0); run_insn(enc_vdot(5'd8, 5'd2, 5'd1), 32'd0, 32'd0);
    expect_rsp(1'b1, 32'd8); run_insn(VSETVLI, 32'd8, 32'd0);
    for (int i = 0; i < 8; i++) expect_mem(32'(3000 + 4*i), 4'b1111, 32'(10 * (i + 1) * (i + 1)));
    expect_rsp(1'b0, 32'd0); run_insn(enc_vsse(5'd8), 32'd3000, 32'd4);

    // Reset while the third load element is outstanding.
    expect_mem(32'd1200, 4'b0000, 32'd0);
    expect_mem(32'd1204, 4'b0000, 32'd0);
    @(negedge clk);
    pcpi_insn = enc_vlse(5'd3); pcpi_cpurs1 = 32'd1200; pcpi_cpurs2 = 32'd4; pcpi_valid = 1'b1;
    req_cnt = 0; prev = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (mem_valid && !prev) req_cnt++;
      prev = mem_valid;
      if (req_cnt == 3) break;
    end
    resetn = 1'b0; pcpi_valid = 1'b0;
    #1;
    check("third_req_reached", 32'(req_cnt), 32'd3);
    check("midop_mem_valid", 32'(mem_valid), 32'd0);
    check("midop_ready", 32'(pcpi_ready), 32'd0);
    check("midop_wait", 32'(pcpi_wait), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    @(negedge clk);
    pcpi_insn = 32'h0010_0093; pcpi_cpurs1 = 32'd0; pcpi_cpurs2 = 32'd0; pcpi_valid = 1'b1;
    saw = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (pcpi_wait || pcpi_ready || pcpi_wr) saw = 1'b1;
    end
    pcpi_valid = 1'b0;
    check("addi_ignored", 32'(saw), 32'd0);

    // vl was cleared by reset, so this store completes with no memory traffic.
    expect_rsp(1'b0, 32'd0); run_insn(enc_vsse(5'd8), 32'd0, 32'd4);
    expect_rsp(1'b1, 32'd2); run_insn(VSETVLI, 32'd2, 32'd0);
    expect_mem(32'd1300, 4'b1111, 32'hA500_0000);
    expect_mem(32'd1304, 4'b1111, 32'hA500_0001);
    expect_rsp(1'b0, 32'd0); run_insn(enc_vsse(5'd3), 32'd1300, 32'd4);

    repeat (5) @(negedge clk);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
